// File: rtl/stack_access_unit.sv
// ---------------------------------------------------------------------------
// stack_access_unit
//   Owns the downward-growing stack pointer and converts Push/Pop requests
//   into single data-memory write/read transactions.
//   SP points at the current top element. SP == SP_TOP means the stack is
//   empty, and SP == SP_LIMIT means it is full.
//
// Ports
//   CLK, Reset       : clock and synchronous active-high reset
//   Push, Pop        : requests, sampled only while idle (Push has priority)
//   PushData         : word to push, captured when the push is accepted
//   MemReady         : memory completes the current access this cycle
//   MemRdData        : read data, valid with MemReady during a read
//   Busy             : an access is in flight
//   PopData/PopValid : last popped word, and a one-cycle update pulse
//   Overflow         : one-cycle pulse when a push is rejected (stack full)
//   Underflow        : one-cycle pulse when a pop is rejected (stack empty)
//   SP               : current stack pointer
//   MemAddr, MemWrData, MemWrite, MemRead : memory port (registered)
// ---------------------------------------------------------------------------
module stack_access_unit #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] SP_TOP     = 16'h8000,
    parameter logic [ADDR_WIDTH-1:0] SP_LIMIT   = 16'h7F00
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  Push,
    input  logic                  Pop,
    input  logic [DATA_WIDTH-1:0] PushData,
    input  logic                  MemReady,
    input  logic [DATA_WIDTH-1:0] MemRdData,
    output logic                  Busy,
    output logic [DATA_WIDTH-1:0] PopData,
    output logic                  PopValid,
    output logic                  Overflow,
    output logic                  Underflow,
    output logic [ADDR_WIDTH-1:0] SP,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic [DATA_WIDTH-1:0] MemWrData,
    output logic                  MemWrite,
    output logic                  MemRead
);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t state;

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    assign Busy = (state != IDLE);

    // MemWrData doubles as the latched push word. It is loaded only when a
    // push is accepted, so it stays stable for the whole write access.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= IDLE;
            SP        <= SP_TOP;
            PopData   <= '0;
            PopValid  <= 1'b0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
            MemWrite  <= 1'b0;
            MemRead   <= 1'b0;
            MemAddr   <= '0;
            MemWrData <= '0;
        end else begin
            // The status flags are single-cycle pulses by construction.
            PopValid  <= 1'b0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
            case (state)
                IDLE: begin
                    if (Push) begin
                        // A simultaneous Pop is dropped. The requester must
                        // issue it again.
                        if (SP == SP_LIMIT) begin
                            Overflow <= 1'b1;
                        end else begin
                            state     <= WRITE;
                            MemWrite  <= 1'b1;
                            MemAddr   <= SP - ONE;
                            MemWrData <= PushData;
                        end
                    end else if (Pop) begin
                        if (SP == SP_TOP) begin
                            Underflow <= 1'b1;
                        end else begin
                            state   <= READ;
                            MemRead <= 1'b1;
                            MemAddr <= SP;
                        end
                    end
                end
                WRITE: begin
                    if (MemReady) begin
                        SP       <= SP - ONE;
                        MemWrite <= 1'b0;
                        state    <= IDLE;
                    end
                end
                READ: begin
                    if (MemReady) begin
                        PopData  <= MemRdData;
                        PopValid <= 1'b1;
                        SP       <= SP + ONE;
                        MemRead  <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    MemWrite <= 1'b0;
                    MemRead  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_access_unit.sv
module tb_stack_access_unit;

    localparam int EV_WR  = 0;
    localparam int EV_RD  = 1;
    localparam int EV_POP = 2;
    localparam int EV_OVF = 3;
    localparam int EV_UNF = 4;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [15:0] data;
    } ev_t;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        Push = 1'b0;
    logic        Pop = 1'b0;
    logic [15:0] PushData = '0;
    logic        MemReady = 1'b1;
    logic [15:0] MemRdData;
    logic        Busy;
    logic [15:0] PopData;
    logic        PopValid;
    logic        Overflow;
    logic        Underflow;
    logic [15:0] SP;
    logic [15:0] MemAddr;
    logic [15:0] MemWrData;
    logic        MemWrite;
    logic        MemRead;

    int checks = 0;
    int fails  = 0;
    ev_t expQ[$];
    logic [15:0] mem [0:65535];

    stack_access_unit dut (
        .CLK(CLK), .Reset(Reset), .Push(Push), .Pop(Pop), .PushData(PushData),
        .MemReady(MemReady), .MemRdData(MemRdData), .Busy(Busy),
        .PopData(PopData), .PopValid(PopValid), .Overflow(Overflow),
        .Underflow(Underflow), .SP(SP), .MemAddr(MemAddr),
        .MemWrData(MemWrData), .MemWrite(MemWrite), .MemRead(MemRead)
    );

    always #5 CLK = ~CLK;

    // Memory model: stores completed writes and returns them on reads.
    always @(posedge CLK) if (MemWrite && MemReady) mem[MemAddr] <= MemWrData;
    assign MemRdData = mem[MemAddr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [15:0] addr, input logic [15:0] data);
        ev_t e;
        e.kind = kind; e.addr = addr; e.data = data;
        expQ.push_back(e);
    endtask

    task automatic compare_ev(input int kind, input logic [15:0] addr, input logic [15:0] data);
        ev_t e;
        if (expQ.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_event: got kind %0d addr %h data %h expected none at %0t",
                     kind, addr, data, $time);
        end else begin
            e = expQ.pop_front();
            check("event_kind", kind, e.kind);
            check("event_addr", addr, e.addr);
            check("event_data", data, e.data);
        end
    endtask

    // Monitor: samples on the falling edge and matches DUT events against the queue.
    always @(negedge CLK) begin
        if (!Reset) begin
            check("wr_rd_exclusive", {31'd0, MemWrite && MemRead}, 32'd0);
            check("pulse_exclusive", 32'(PopValid) + 32'(Overflow) + 32'(Underflow) > 1, 32'd0);
            if (MemWrite && MemReady) compare_ev(EV_WR, MemAddr, MemWrData);
            if (MemRead && MemReady)  compare_ev(EV_RD, MemAddr, 16'h0);
            if (PopValid)             compare_ev(EV_POP, 16'h0, PopData);
            if (Overflow)             compare_ev(EV_OVF, 16'h0, 16'h0);
            if (Underflow)            compare_ev(EV_UNF, 16'h0, 16'h0);
        end
    end

    task automatic cyc;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        Reset = 1'b1; Push = 1'b0; Pop = 1'b0;
        cyc; cyc;
        Reset = 1'b0;
    endtask

    // One push with MemReady high: Busy is high for exactly one cycle.
    task automatic do_push(input logic [15:0] d, input logic [15:0] addr);
        expect_ev(EV_WR, addr, d);
        Push = 1'b1; PushData = d;
        cyc;
        Push = 1'b0;
        check("push_busy1", Busy, 1'b1);
        cyc;
        check("push_busy0", Busy, 1'b0);
        check("push_sp", SP, addr);
    endtask

    task automatic do_pop(input logic [15:0] addr, input logic [15:0] d);
        expect_ev(EV_RD, addr, 16'h0);
        expect_ev(EV_POP, 16'h0, d);
        Pop = 1'b1;
        cyc;
        Pop = 1'b0;
        check("pop_busy1", Busy, 1'b1);
        cyc;
        check("pop_busy0", Busy, 1'b0);
        check("pop_valid", PopValid, 1'b1);
        check("pop_data", PopData, d);
        check("pop_sp", SP, addr + 16'h1);
        cyc;
        check("pop_valid_drop", PopValid, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset, then three idle cycles
        do_reset;
        check("rst_sp", SP, 16'h8000);
        check("rst_popdata", PopData, 16'h0);
        check("rst_memaddr", MemAddr, 16'h0);
        check("rst_memwrdata", MemWrData, 16'h0);
        cyc; cyc; cyc;
        check("idle_sp", SP, 16'h8000);
        check("idle_busy", Busy, 1'b0);
        check("idle_strobes", {MemWrite, MemRead, PopValid, Overflow, Underflow}, 5'b0);

        // 2: two pushes
        do_push(16'h1234, 16'h7FFF);
        do_push(16'hABCD, 16'h7FFE);
        check("s2_sp", SP, 16'h7FFE);

        // 3: two pops, LIFO order
        do_pop(16'h7FFE, 16'hABCD);
        do_pop(16'h7FFF, 16'h1234);
        check("s3_sp", SP, 16'h8000);

        // 4: underflow, then fill the stack and overflow
        expect_ev(EV_UNF, 16'h0, 16'h0);
        Pop = 1'b1;
        cyc;
        Pop = 1'b0;
        check("unf_pulse", Underflow, 1'b1);
        check("unf_busy", Busy, 1'b0);
        check("unf_memread", MemRead, 1'b0);
        cyc;
        check("unf_pulse_drop", Underflow, 1'b0);
        check("unf_sp", SP, 16'h8000);
        for (int i = 0; i < 256; i++) do_push(16'h1000 + 16'(i), 16'h7FFF - 16'(i));
        check("full_sp", SP, 16'h7F00);
        expect_ev(EV_OVF, 16'h0, 16'h0);
        Push = 1'b1; PushData = 16'hDEAD;
        cyc;
        Push = 1'b0;
        check("ovf_pulse", Overflow, 1'b1);
        check("ovf_busy", Busy, 1'b0);
        check("ovf_memwrite", MemWrite, 1'b0);
        cyc;
        check("ovf_pulse_drop", Overflow, 1'b0);
        check("ovf_sp", SP, 16'h7F00);

        // 5: push held off by MemReady=0 for four cycles; push during Busy ignored
        do_reset;
        MemReady = 1'b0;
        expect_ev(EV_WR, 16'h7FFF, 16'h5A5A);
        Push = 1'b1; PushData = 16'h5A5A;
        cyc;
        PushData = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            check("stall_memwrite", MemWrite, 1'b1);
            check("stall_memaddr", MemAddr, 16'h7FFF);
            check("stall_memwrdata", MemWrData, 16'h5A5A);
            check("stall_sp", SP, 16'h8000);
            if (i == 4) begin
                MemReady = 1'b1;
                Push = 1'b0;
            end
            cyc;
        end
        check("stall_done_sp", SP, 16'h7FFF);
        check("stall_done_busy", Busy, 1'b0);
        cyc;
        check("stall_no_repush", Busy, 1'b0);
        check("stall_no_repush_sp", SP, 16'h7FFF);

        // 6: Push and Pop together -> push only; reset during READ
        expect_ev(EV_WR, 16'h7FFE, 16'hC0DE);
        Push = 1'b1; Pop = 1'b1; PushData = 16'hC0DE;
        cyc;
        Push = 1'b0; Pop = 1'b0;
        check("both_memwrite", MemWrite, 1'b1);
        check("both_memread", MemRead, 1'b0);
        cyc;
        check("both_sp", SP, 16'h7FFE);
        cyc;
        check("both_no_pop", Busy, 1'b0);
        MemReady = 1'b0;
        Pop = 1'b1;
        cyc;
        Pop = 1'b0;
        check("rdrst_memread", MemRead, 1'b1);
        check("rdrst_memaddr", MemAddr, 16'h7FFE);
        cyc;
        Reset = 1'b1;
        cyc;
        Reset = 1'b0;
        MemReady = 1'b1;
        check("rdrst_busy", Busy, 1'b0);
        check("rdrst_sp", SP, 16'h8000);
        check("rdrst_memread0", MemRead, 1'b0);
        check("rdrst_popvalid", PopValid, 1'b0);
        cyc;
        check("rdrst_popvalid2", PopValid, 1'b0);
        check("rdrst_sp2", SP, 16'h8000);

        cyc; cyc;
        check("queue_empty", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
